// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_arbiter_pkg;

  // Width of the latency down-counter; bounds LATENCY to 1..15.
  localparam int CNT_W = 4;

  // Transaction FSM: only IDLE arbitrates, BUSY waits out memory latency,
  // RESP issues the one-cycle completion pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // Counter preload for a given read latency (counts LATENCY-1 down to 0).
  function automatic logic [CNT_W-1:0] cnt_load(input int lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational 2-way round-robin select. On a tie the master that did not
// own the last transaction wins; otherwise whichever master is requesting.
module rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant,
  output logic valid
);

  // Tie goes to the master other than the last owner.
  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) grant = ~last;
    else              grant = req1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-port memory with fixed read
// latency. One transaction in flight at a time; requests are latched at
// grant so masters may change their inputs afterwards without effect.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("mem_arbiter: LATENCY must be in 1..15");
  end

  localparam logic [CNT_W-1:0] CNT_LOAD = cnt_load(LATENCY);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic pick_gnt, pick_vld;

  rr_pick u_pick (
    .req0  (m0_req),
    .req1  (m1_req),
    .last  (owner_q),
    .grant (pick_gnt),
    .valid (pick_vld)
  );

  // Next-state, latch capture and per-state outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    mem_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
          owner_d = pick_gnt;
          we_d    = pick_gnt ? m1_we    : m0_we;
          addr_d  = pick_gnt ? m1_addr  : m0_addr;
          wdata_d = pick_gnt ? m1_wdata : m0_wdata;
        end
      end
      BUSY: begin
        // The counter only moves down while in BUSY, so it still equals the
        // preload exactly in the first BUSY cycle: the single write strobe.
        mem_we = we_q && (cnt_q == CNT_LOAD);
        if (cnt_q == '0) begin
          state_d = RESP;
          if (!we_q) begin
            if (owner_q) rdata1_d = mem_rdata;
            else         rdata0_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        m0_ack  = ~owner_q;
        m1_ack  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      owner_q  <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Memory side is driven straight from the latches, so it holds the last
  // transaction's values while idle.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign owner     = owner_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (LATENCY 1 and 3) share stimulus and
// are each tracked by a transaction-timeline reference model.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0, mem_rdata = '0;

  logic          m0_ack [2];
  logic          m1_ack [2];
  logic          mem_we [2];
  logic          busy   [2];
  logic          owner  [2];
  logic [DW-1:0] m0_rdata [2];
  logic [DW-1:0] m1_rdata [2];
  logic [DW-1:0] mem_wdata[2];
  logic [AW-1:0] mem_addr [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(2*gi+1)) u_dut (
      .clk(clk), .resetn(resetn),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack[gi]), .m0_rdata(m0_rdata[gi]),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack[gi]), .m1_rdata(m1_rdata[gi]),
      .mem_addr(mem_addr[gi]), .mem_wdata(mem_wdata[gi]), .mem_we(mem_we[gi]),
      .mem_rdata(mem_rdata), .busy(busy[gi]), .owner(owner[gi])
    );
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: each transaction is a timeline counted from its grant
  // cycle (1..L busy, L+1 ack, then idle again).
  int            lat_m [2] = '{1, 3};
  int            idx_m [2];
  logic          own_m [2];
  logic          we_m  [2];
  logic [AW-1:0] addr_m[2];
  logic [DW-1:0] wd_m  [2];
  logic [DW-1:0] rd0_m [2];
  logic [DW-1:0] rd1_m [2];
  bit            known = 1'b0;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (known) begin
        chk($sformatf("L%0d busy", lat_m[k]), busy[k], idx_m[k] != 0);
        chk($sformatf("L%0d mem_we", lat_m[k]), mem_we[k], idx_m[k] == 1 && we_m[k]);
        chk($sformatf("L%0d m0_ack", lat_m[k]), m0_ack[k], idx_m[k] == lat_m[k] + 1 && !own_m[k]);
        chk($sformatf("L%0d m1_ack", lat_m[k]), m1_ack[k], idx_m[k] == lat_m[k] + 1 && own_m[k]);
        chk($sformatf("L%0d ack_excl", lat_m[k]), m0_ack[k] & m1_ack[k], 0);
        chk($sformatf("L%0d owner", lat_m[k]), owner[k], own_m[k]);
        chk($sformatf("L%0d mem_addr", lat_m[k]), mem_addr[k], addr_m[k]);
        chk($sformatf("L%0d mem_wdata", lat_m[k]), mem_wdata[k], wd_m[k]);
        chk($sformatf("L%0d m0_rdata", lat_m[k]), m0_rdata[k], rd0_m[k]);
        chk($sformatf("L%0d m1_rdata", lat_m[k]), m1_rdata[k], rd1_m[k]);
      end
      if (!resetn) begin
        idx_m[k] = 0; own_m[k] = 1'b1; we_m[k] = 1'b0;
        addr_m[k] = '0; wd_m[k] = '0; rd0_m[k] = '0; rd1_m[k] = '0;
      end else if (idx_m[k] == 0) begin
        if (m0_req || m1_req) begin
          own_m[k]  = (m0_req && m1_req) ? !own_m[k] : m1_req;
          we_m[k]   = own_m[k] ? m1_we    : m0_we;
          addr_m[k] = own_m[k] ? m1_addr  : m0_addr;
          wd_m[k]   = own_m[k] ? m1_wdata : m0_wdata;
          idx_m[k]  = 1;
        end
      end else if (idx_m[k] == lat_m[k] + 1) begin
        idx_m[k] = 0;
      end else begin
        if (idx_m[k] == lat_m[k] && !we_m[k]) begin
          if (own_m[k]) rd1_m[k] = mem_rdata;
          else          rd0_m[k] = mem_rdata;
        end
        idx_m[k]++;
      end
    end
    if (!resetn) known = 1'b1;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    m0_req = 1'b0; m1_req = 1'b0; resetn = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  task automatic idle(input int n);
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (n) tick();
  endtask

  int            order[$];
  int            nwe;
  int            nack;
  logic [DW-1:0] saved;
  bit            got_ack;

  initial begin
    resetn = 1'b0;
    tick(); tick();
    resetn = 1'b1;

    // Single read at LATENCY=1: address in t+1, ack and data in t+2.
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100; mem_rdata = 32'hDEADBEEF;
    tick();
    @(negedge clk);
    chk("t23 mem_addr", mem_addr[0], 32'h100);
    chk("t23 mem_we", mem_we[0], 0);
    tick();
    m0_req = 1'b0;
    @(negedge clk);
    chk("t23 ack", m0_ack[0], 1);
    chk("t23 rdata", m0_rdata[0], 32'hDEADBEEF);
    idle(5);

    // Tie after reset: m0 read first, then m1 write with one strobe.
    do_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h55;
    order.delete(); nwe = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (mem_we[0]) begin
        nwe++;
        chk("t24 we_addr", mem_addr[0], 32'h20);
        chk("t24 we_data", mem_wdata[0], 32'h55);
      end
      if (m0_ack[0]) order.push_back(0);
      if (m1_ack[0]) order.push_back(1);
      tick();
      if (order.size() > 0 && order[order.size()-1] == 0) m0_req = 1'b0;
      if (order.size() > 0 && order[order.size()-1] == 1) m1_req = 1'b0;
    end
    chk("t24 nack", order.size(), 2);
    chk("t24 first", order.size() > 0 ? order[0] : 9, 0);
    chk("t24 second", order.size() > 1 ? order[1] : 9, 1);
    chk("t24 nwe", nwe, 1);
    idle(6);

    // Saturation: owners alternate starting with master 0.
    do_reset();
    m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b0; m1_we = 1'b0;
    nack = 0;
    for (int c = 0; c < 40 && nack < 8; c++) begin
      @(negedge clk);
      if (m0_ack[0] || m1_ack[0]) begin
        chk("t25 rr_owner", m1_ack[0], nack % 2);
        nack++;
      end
      tick();
    end
    chk("t25 nack", nack, 8);
    idle(6);

    // LATENCY=3: m1 read ack at t+4 with data from t+3; re-grant at t+5.
    do_reset();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h40;
    saved = '0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      mem_rdata = $urandom;
      @(negedge clk);
      if (c == 3) begin
        saved = mem_rdata;
        chk("t26 early_ack", m1_ack[1], 0);
      end
      if (c == 4) begin
        chk("t26 ack", m1_ack[1], 1);
        chk("t26 rdata", m1_rdata[1], saved);
      end
      if (c == 5) chk("t26 idle", busy[1], 0);
      if (c == 6) begin
        chk("t26 regrant", busy[1], 1);
        chk("t26 owner", owner[1], 1);
      end
    end
    idle(8);

    // Reset in mid-BUSY on the LATENCY=3 instance abandons the write.
    do_reset();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h80; m0_wdata = 32'h77;
    tick(); tick();
    resetn = 1'b0; m0_req = 1'b0;
    tick();
    resetn = 1'b1;
    @(negedge clk);
    chk("t27 busy", busy[1], 0);
    chk("t27 mem_we", mem_we[1], 0);
    chk("t27 mem_addr", mem_addr[1], 0);
    for (int c = 0; c < 4; c++) begin
      chk("t27 no_ack", m0_ack[1], 0);
      tick();
      @(negedge clk);
    end
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h84;
    got_ack = 1'b0;
    for (int c = 0; c < 10 && !got_ack; c++) begin
      tick();
      @(negedge clk);
      if (m0_ack[1]) got_ack = 1'b1;
    end
    chk("t27 recover_ack", got_ack, 1);
    idle(8);

    // Address change after grant is ignored.
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h300;
    tick();
    m0_addr = 32'h999;
    @(negedge clk);
    chk("t28 addr_l1", mem_addr[0], 32'h300);
    chk("t28 addr_l3", mem_addr[1], 32'h300);
    tick();
    m0_req = 1'b0;
    @(negedge clk);
    chk("t28 addr_l3_hold", mem_addr[1], 32'h300);
    idle(8);

    // Random traffic, including occasional resets and input churn.
    for (int c = 0; c < 600; c++) begin
      resetn    = ($urandom_range(0, 59) != 0);
      m0_req    = ($urandom_range(0, 3) != 0);
      m1_req    = ($urandom_range(0, 2) != 0);
      m0_we     = $urandom_range(0, 1);
      m1_we     = $urandom_range(0, 1);
      m0_addr   = $urandom;
      m1_addr   = $urandom;
      m0_wdata  = $urandom;
      m1_wdata  = $urandom;
      mem_rdata = $urandom;
      tick();
    end
    resetn = 1'b1;
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 32, address width; DATA_W, 32, data width; LATENCY, 1, memory read latency in cycles (legal 1..15; 0 rejected at elaboration).
REQ-002 Ports SHALL be (name direction width meaning), clock and reset first:
  clk  in  1  sole clock, rising edge
  resetn  in  1  reset, synchronous, active-low
  m0_req  in  1  master 0 (core) request
  m0_we  in  1  master 0 write, 1=write
  m0_addr  in  ADDR_W  master 0 address
  m0_wdata  in  DATA_W  master 0 write data
  m0_ack  out  1  master 0 completion pulse
  m0_rdata  out  DATA_W  master 0 read data
  m1_req / m1_we / m1_addr / m1_wdata / m1_ack / m1_rdata  same widths and meaning for master 1 (loader/debug)
  mem_addr  out  ADDR_W  shared memory address
  mem_wdata  out  DATA_W  shared memory write data
  mem_we  out  1  shared memory write enable
  mem_rdata  in  DATA_W  shared memory read data
  busy  out  1  transaction in flight (state != IDLE)
  owner  out  1  index of master owning current/last transaction
REQ-003 One clock; reset is synchronous and active-low, ports named clk and resetn.

Function
REQ-004 FSM states SHALL be IDLE, BUSY, RESP; only IDLE arbitrates.
REQ-005 In IDLE, if exactly one mN_req is high, that master SHALL be granted at the clock edge ending the cycle.
REQ-006 If both reqs are high in IDLE, the master not equal to owner SHALL be granted (round-robin).
REQ-007 On grant: addr, wdata, we of winner latched; owner updated; state -> BUSY; 4-bit counter loaded with LATENCY-1.
REQ-008 mem_addr and mem_wdata SHALL be driven from the latches from the first BUSY cycle until leaving RESP; undefined-free (hold last value) otherwise.
REQ-009 mem_we SHALL be high in the first BUSY cycle only, and only for a write; never in IDLE or RESP.
REQ-010 In BUSY, counter decrements each cycle; when counter==0, mem_rdata sampled into owner's rdata register and state -> RESP.
REQ-011 In RESP, owner's mN_ack SHALL be high for exactly one cycle; state -> IDLE next.
REQ-012 Latency: request sampled in IDLE at cycle t -> ack in cycle t+LATENCY+1; next arbitration in cycle t+LATENCY+2; throughput one transaction per LATENCY+2 cycles.
REQ-013 mN_rdata SHALL hold its value until that master's next read completes; writes SHALL not alter it.
REQ-014 Masters SHALL hold req/we/addr/wdata stable until ack; changes before ack are ignored (latched values used).
REQ-015 A req still high in the cycle after ack SHALL be treated as a new request.
REQ-016 The non-granted master's req SHALL remain pending and be granted at the next IDLE (no starvation: at most one intervening transaction).
REQ-017 m0_ack and m1_ack SHALL never be high in the same cycle.

Reset
REQ-018 At a clock edge with resetn low: state=IDLE, counter=0, owner=1 (master 0 wins first tie), latches=0, m0_rdata=m1_rdata=0.
REQ-019 Following such an edge: m0_ack=m1_ack=0, mem_we=0, busy=0, mem_addr=mem_wdata=0.
REQ-020 Reset in BUSY or RESP SHALL abandon the transaction: no ack issued, no further mem_we.

Structure
REQ-021 Shared package mem_arbiter_pkg SHALL hold the state enum (IDLE, BUSY, RESP) and the counter width constant (4).
REQ-022 One sub-module rr_pick (combinational 2-way round-robin select: req0, req1, last -> grant, valid) is natural; FSM, counter, latches stay in mem_arbiter.

Verification
REQ-023 Single read, LATENCY=1: m0 read 0x100, memory returns 0xDEADBEEF -> mem_addr=0x100 in t+1, m0_ack and m0_rdata=0xDEADBEEF in t+2, mem_we never high.
REQ-024 Simultaneous requests after reset: m0 read 0x10, m1 write 0x20/0x55 -> m0 served first, then m1; mem_we high exactly one cycle with mem_addr=0x20, mem_wdata=0x55.
REQ-025 Round-robin under saturation: both reqs held high for 8 transactions -> owners alternate 0,1,0,1,...; acks never coincide.
REQ-026 LATENCY=3: m1 read at t -> ack at t+4, rdata equals mem_rdata sampled in t+3; m1_req held high after ack -> second grant at t+5.
REQ-027 Reset mid-BUSY: resetn low for one cycle during m0 write -> no m0_ack, mem_we=0, busy=0 after the edge; next m0 request completes normally.
REQ-028 Address change before ack: m0_addr altered in BUSY -> mem_addr keeps originally latched value.
